decoder_scan_ctrl: RTL and testbench
====================================

Name: decoder_scan_ctrl

Overview:
Sequencer that drives the 3-to-8 decoder's select and enable inputs. It steps round-robin through the enabled channels. Each selected line is held active for a programmable dwell time, then a blanking gap keeps the decoder disabled before the next channel. The block feeds scanned-output loads such as digit strobes and row drivers. It sits between the control logic (start/stop, mask, dwell) and the decoder.

Parameters:
DW, 8, width of the dwell-count input and internal dwell counter
BLANK, 2, decoder-disabled cycles between channels; 0 = no gap

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request to begin scanning; ignored while busy
stop  input  1  abort scanning; takes priority over start
mode  input  1  0 = continuous scan, 1 = single sweep then idle
ch_mask  input  8  bit i = 1 means channel i is scanned; sampled at each channel advance
dwell  input  DW  active cycles per channel; sampled at channel entry; 0 is treated as 1
sel  output  3  decoder select (decoder data_in)
sel_en  output  1  decoder enable
busy  output  1  high from the cycle after an accepted start until the return to IDLE
ch_strobe  output  1  one-cycle pulse on the first active cycle of each channel
sweep_done  output  1  one-cycle pulse when a sweep completes

Behaviour:
- Single clock domain. rst_n is an asynchronous assert with a synchronous deassert handled upstream.
- Reset values: sel=0, sel_en=0, busy=0, ch_strobe=0, sweep_done=0, FSM=IDLE, counters=0.
- All outputs are registered.
- States: IDLE, ACTIVE, BLANK.
- IDLE:
  - On start=1, stop=0 and ch_mask!=0: go to ACTIVE on the next edge.
  - sel = lowest set mask bit; sel_en=1, ch_strobe=1, busy=1.
  - Latency from start sampled to sel_en high is 1 cycle.
  - start with ch_mask=0 is ignored: stay in IDLE, busy stays 0.
- ACTIVE:
  - sel_en=1 for exactly max(dwell,1) cycles.
  - Then go to BLANK if BLANK>0, else advance directly.
- BLANK:
  - sel_en=0 and sel holds its value for exactly BLANK cycles, then advance.
- Advance:
  - Next channel = first set ch_mask bit searching upward from sel+1, modulo 8.
  - A wrap occurs when the next index <= the current index. This includes a single enabled channel, which wraps to itself.
  - On wrap: sweep_done pulses together with the transition out of the last channel. In mode=1 the FSM then goes to IDLE (sel_en=0, busy=0 that same edge). In mode=0 scanning continues.
  - Non-wrap: go to ACTIVE on the new channel; ch_strobe pulses.
  - With BLANK=0, consecutive channels appear back to back with sel_en continuously high; only sel changes.
- Mask changes:
  - ch_mask is sampled only at advance; mid-channel changes do not cut the current dwell short.
  - If ch_mask=0 at advance: go to IDLE with no sweep_done.
- stop=1 in any non-IDLE state: next edge goes to IDLE with sel_en=0 and busy=0; sel keeps its last value; no sweep_done.
- start while busy has no effect.
- mode is sampled at each advance.
- Reset mid-operation: all outputs go to their reset values immediately, independent of clk.
- sel_en is never high while the FSM is in BLANK or IDLE. sel never changes while sel_en=1 within one channel.

Test Plan:
- Reset/idle: rst_n=0 for 3 cycles, then 1, no start -> sel=0, sel_en=0, busy=0 throughout; start with ch_mask=8'h00 -> busy stays 0.
- Single sweep: mask=8'b0010_0101, dwell=3, BLANK=2, mode=1, start -> sel sequence 0,2,5; each has sel_en high 3 cycles then low 2 cycles; 3 ch_strobe pulses; sweep_done pulses once as channel 5 ends; busy falls at that edge.
- Continuous wrap: mask=8'h81, dwell=1, mode=0 -> sel alternates 7,0,7,...; sweep_done pulses each time 7->0.
- Zero dwell / no blank: dwell=0, BLANK=0, mask=8'hFF, mode=0 -> sel increments 0..7 every cycle with sel_en constant 1; sweep_done every 8 cycles.
- Stop priority: start and stop asserted together -> stays IDLE; stop mid-ACTIVE on channel 2 -> next cycle sel_en=0, busy=0, sel=2, no sweep_done.
- Mask/reset mid-scan: clear ch_mask during ACTIVE -> current dwell completes, then IDLE with no sweep_done; assert rst_n=0 mid-dwell -> sel_en=0 and sel=0 before the next clk edge.

Source files
------------

// File: rtl/decoder_scan_ctrl.sv
// ----------------------------------------------------------------------------
// decoder_scan_ctrl
// Round-robin sequencer for a 3-to-8 decoder. It steps through the channels
// enabled in ch_mask. Each channel's line is held for a programmable dwell,
// and an optional blanking gap with the decoder disabled follows each channel.
//
// Parameters
//   DW    : width of the dwell input and the dwell counter
//   BLANK : decoder-disabled cycles between channels (0 = back to back)
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   request to begin scanning (ignored while busy)
//   stop       in   abort scanning; has priority over start
//   mode       in   0 = continuous, 1 = single sweep (sampled at advance)
//   ch_mask    in   per-channel enable (sampled at start and at advance)
//   dwell      in   active cycles per channel, 0 treated as 1
//   sel        out  decoder select
//   sel_en     out  decoder enable
//   busy       out  scanning in progress
//   ch_strobe  out  pulse on the first active cycle of each channel
//   sweep_done out  pulse when the scan wraps past the highest channel
// ----------------------------------------------------------------------------
module decoder_scan_ctrl #(
    parameter int DW    = 8,
    parameter int BLANK = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic          mode,
    input  logic [7:0]    ch_mask,
    input  logic [DW-1:0] dwell,
    output logic [2:0]    sel,
    output logic          sel_en,
    output logic          busy,
    output logic          ch_strobe,
    output logic          sweep_done
);

    // One counter serves both the dwell phase and the blanking phase.
    localparam int BW = (BLANK > 1) ? $clog2(BLANK) : 1;
    localparam int CW = (DW > BW) ? DW : BW;
    localparam logic [CW-1:0] BLANK_LOAD = CW'((BLANK > 0) ? (BLANK - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_BLANK
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    sel_q, sel_d;
    logic          sel_en_q, sel_en_d;
    logic          busy_q, busy_d;
    logic          strobe_q, strobe_d;
    logic          done_q, done_d;

    logic [2:0]    lo_ch;
    logic [2:0]    nx_ch;
    logic [2:0]    idx;
    logic          wrap;
    logic          adv;
    logic [CW-1:0] dwell_load;

    // Counter holds remaining cycles minus one, so a zero dwell loads 0
    // and behaves like a dwell of 1.
    assign dwell_load = (dwell == '0) ? '0 : CW'(dwell - DW'(1));

    // Channel search. Both loops run from the far end toward the near end, so
    // the last match is the nearest channel. k = 8 folds back to sel_q itself,
    // which covers a mask with a single enabled channel.
    always_comb begin
        lo_ch = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (ch_mask[7 - i]) lo_ch = 3'(7 - i);
        end
        nx_ch = sel_q;
        idx   = '0;
        for (int unsigned k = 8; k >= 1; k--) begin
            idx = sel_q + 3'(k);
            if (ch_mask[idx]) nx_ch = idx;
        end
        wrap = (nx_ch <= sel_q);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        sel_en_d = sel_en_q;
        busy_d   = busy_q;
        strobe_d = 1'b0;
        done_d   = 1'b0;
        adv      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start && !stop && (ch_mask != '0)) begin
                    state_d  = ST_ACTIVE;
                    sel_d    = lo_ch;
                    sel_en_d = 1'b1;
                    busy_d   = 1'b1;
                    strobe_d = 1'b1;
                    cnt_d    = dwell_load;
                end
            end
            ST_ACTIVE: begin
                if (cnt_q == '0) begin
                    if (BLANK > 0) begin
                        state_d  = ST_BLANK;
                        sel_en_d = 1'b0;
                        cnt_d    = BLANK_LOAD;
                    end else begin
                        adv = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_BLANK: begin
                if (cnt_q == '0) adv = 1'b1;
                else             cnt_d = cnt_q - CW'(1);
            end
            default: state_d = ST_IDLE;
        endcase

        if (adv) begin
            if (ch_mask == '0) begin
                state_d  = ST_IDLE;
                sel_en_d = 1'b0;
                busy_d   = 1'b0;
            end else begin
                done_d = wrap;
                if (wrap && mode) begin
                    state_d  = ST_IDLE;
                    sel_en_d = 1'b0;
                    busy_d   = 1'b0;
                end else begin
                    state_d  = ST_ACTIVE;
                    sel_d    = nx_ch;
                    sel_en_d = 1'b1;
                    strobe_d = 1'b1;
                    cnt_d    = dwell_load;
                end
            end
        end

        // Stop overrides whatever the phase logic above decided; sel is held.
        if (stop && (state_q != ST_IDLE)) begin
            state_d  = ST_IDLE;
            sel_d    = sel_q;
            sel_en_d = 1'b0;
            busy_d   = 1'b0;
            strobe_d = 1'b0;
            done_d   = 1'b0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            sel_q    <= '0;
            sel_en_q <= 1'b0;
            busy_q   <= 1'b0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            sel_en_q <= sel_en_d;
            busy_q   <= busy_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
        end
    end

    assign sel        = sel_q;
    assign sel_en     = sel_en_q;
    assign busy       = busy_q;
    assign ch_strobe  = strobe_q;
    assign sweep_done = done_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// ----------------------------------------------------------------------------
// tb_decoder_scan_ctrl
// Two instances share one stimulus stream: u_dut_a uses BLANK=2 and u_dut_b
// uses BLANK=0. Each instance is compared every cycle against a slot-based
// reference model. In that model a channel occupies dwell+BLANK cycles, and
// the line is enabled during the first dwell cycles of its slot.
// ----------------------------------------------------------------------------
module tb_decoder_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] ch_mask = '0;
    logic [7:0] dwell = '0;

    logic [2:0] sel_a, sel_b;
    logic       en_a, en_b, busy_a, busy_b, stb_a, stb_b, done_a, done_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    decoder_scan_ctrl #(.DW(8), .BLANK(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
        .ch_mask(ch_mask), .dwell(dwell), .sel(sel_a), .sel_en(en_a),
        .busy(busy_a), .ch_strobe(stb_a), .sweep_done(done_a)
    );

    decoder_scan_ctrl #(.DW(8), .BLANK(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
        .ch_mask(ch_mask), .dwell(dwell), .sel(sel_b), .sel_en(en_b),
        .busy(busy_b), .ch_strobe(stb_b), .sweep_done(done_b)
    );

    // ---------------- reference model ----------------
    typedef struct {
        bit busy;
        int ch;
        int d;
        int pos;
        bit en;
        bit strobe;
        bit done;
    } model_t;

    model_t m_a, m_b;

    function automatic model_t model_reset();
        model_t m;
        m.busy = 0; m.ch = 0; m.d = 1; m.pos = 0;
        m.en = 0; m.strobe = 0; m.done = 0;
        return m;
    endfunction

    function automatic int lowest(logic [7:0] mk);
        for (int i = 0; i < 8; i++) if (mk[i]) return i;
        return 0;
    endfunction

    function automatic int next_ch(int ch, logic [7:0] mk);
        for (int k = 1; k <= 8; k++) if (mk[(ch + k) % 8]) return (ch + k) % 8;
        return ch;
    endfunction

    function automatic model_t model_step(model_t m, int blank, logic st, logic sp,
                                          logic md, logic [7:0] mk, logic [7:0] dw);
        model_t n = m;
        int nx;
        n.strobe = 0;
        n.done = 0;
        if (!m.busy) begin
            if (st && !sp && mk != 0) begin
                n.busy = 1; n.ch = lowest(mk); n.d = (dw == 0) ? 1 : int'(dw);
                n.pos = 0; n.strobe = 1;
            end
        end else if (sp) begin
            n.busy = 0;
        end else if (m.pos + 1 < m.d + blank) begin
            n.pos = m.pos + 1;
        end else if (mk == 0) begin
            n.busy = 0;
        end else begin
            nx = next_ch(m.ch, mk);
            n.done = (nx <= m.ch);
            if (n.done && md) begin
                n.busy = 0;
            end else begin
                n.ch = nx; n.d = (dw == 0) ? 1 : int'(dw);
                n.pos = 0; n.strobe = 1;
            end
        end
        n.en = n.busy && (n.pos < n.d);
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_a = model_reset();
            m_b = model_reset();
        end else begin
            m_a = model_step(m_a, 2, start, stop, mode, ch_mask, dwell);
            m_b = model_step(m_b, 0, start, stop, mode, ch_mask, dwell);
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        chk("a.sel",  int'(sel_a),  m_a.ch);
        chk("a.en",   int'(en_a),   int'(m_a.en));
        chk("a.busy", int'(busy_a), int'(m_a.busy));
        chk("a.stb",  int'(stb_a),  int'(m_a.strobe));
        chk("a.done", int'(done_a), int'(m_a.done));
        chk("b.sel",  int'(sel_b),  m_b.ch);
        chk("b.en",   int'(en_b),   int'(m_b.en));
        chk("b.busy", int'(busy_b), int'(m_b.busy));
        chk("b.stb",  int'(stb_b),  int'(m_b.strobe));
        chk("b.done", int'(done_b), int'(m_b.done));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    int n_stb;
    int n_done;

    initial begin
        m_a = model_reset();
        m_b = model_reset();

        // reset and idle
        run(3);
        rst_n = 1'b1;
        run(4);
        ch_mask = 8'h00;
        pulse_start();
        run(2);

        // start and stop together
        ch_mask = 8'h0F; dwell = 8'd2;
        start = 1'b1; stop = 1'b1;
        cycle();
        start = 1'b0; stop = 1'b0;
        run(2);

        // single sweep 0,2,5
        ch_mask = 8'b0010_0101; dwell = 8'd3; mode = 1'b1;
        start = 1'b1;
        n_stb = 0; n_done = 0;
        for (int i = 0; i < 30; i++) begin
            cycle();
            start = 1'b0;
            n_stb += int'(stb_a);
            n_done += int'(done_a);
        end
        chk("sweep.strobes", n_stb, 3);
        chk("sweep.done", n_done, 1);

        // continuous wrap 7 <-> 0
        ch_mask = 8'h81; dwell = 8'd1; mode = 1'b0;
        pulse_start();
        run(20);
        stop = 1'b1; cycle(); stop = 1'b0;
        run(2);

        // zero dwell, all channels
        ch_mask = 8'hFF; dwell = 8'd0;
        pulse_start();
        run(24);
        stop = 1'b1; cycle(); stop = 1'b0;
        run(2);

        // stop mid-ACTIVE on channel 2
        ch_mask = 8'h04; dwell = 8'd5;
        pulse_start();
        run(2);
        stop = 1'b1; cycle(); stop = 1'b0;
        chk("stop.sel", int'(sel_a), 2);
        run(2);

        // mask cleared mid-dwell
        ch_mask = 8'h0F; dwell = 8'd6;
        pulse_start();
        run(2);
        ch_mask = 8'h00;
        run(15);

        // asynchronous reset mid-dwell
        ch_mask = 8'hF0; dwell = 8'd10;
        pulse_start();
        run(3);
        rst_n = 1'b0;
        #1;
        chk("arst.en", int'(en_a), 0);
        chk("arst.sel", int'(sel_a), 0);
        chk("arst.busy", int'(busy_b), 0);
        run(2);
        rst_n = 1'b1;
        run(2);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 7) == 0);
            stop  = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 31) == 0) begin
                ch_mask = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
                dwell   = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 20))
                                                      : 8'($urandom_range(0, 4));
                mode    = 1'($urandom_range(0, 1));
            end
            cycle();
        end
        start = 1'b0; stop = 1'b0;
        run(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
